// File: rtl/regfile_access_sequencer.sv
// Sequences the 16x32 register bank for the calculator datapath: arbitrates an
// operation port (read Rn/Rm, ALU, write Rd) and a display readback port.
module regfile_access_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rn,
  input  logic [ADDR_W-1:0] cmd_rm,
  input  logic              cmd_imm_sel,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_no_wb,
  output logic              cmd_ack,
  output logic              cmd_done,
  output logic [DATA_W-1:0] cmd_result,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_ack,
  output logic              dsp_valid,
  output logic [DATA_W-1:0] dsp_data,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3_n,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              rr_q, rr_d;        // 0: operation port preferred on conflict
  logic              sel_q, sel_d;      // 1: current transaction is a display read
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              imm_sel_q, imm_sel_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              no_wb_q, no_wb_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic              cmd_done_q, cmd_done_d;
  logic [DATA_W-1:0] cmd_result_q, cmd_result_d;
  logic              dsp_ack_q, dsp_ack_d;
  logic              dsp_valid_q, dsp_valid_d;
  logic [DATA_W-1:0] dsp_data_q, dsp_data_d;
  logic [ADDR_W-1:0] rf_a1_q, rf_a1_d;
  logic [ADDR_W-1:0] rf_a2_q, rf_a2_d;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
  logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
  logic              rf_we3_n_q, rf_we3_n_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              grant_cmd_s, grant_dsp_s;

  // Round-robin grant decision between the two requesters.
  always_comb begin
    grant_cmd_s = 1'b0;
    grant_dsp_s = 1'b0;
    if (cmd_valid && dsp_req) begin
      grant_cmd_s = ~rr_q;
      grant_dsp_s = rr_q;
    end else begin
      grant_cmd_s = cmd_valid;
      grant_dsp_s = dsp_req;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    op_d         = op_q;
    rd_d         = rd_q;
    imm_sel_d    = imm_sel_q;
    imm_d        = imm_q;
    no_wb_d      = no_wb_q;
    cmd_ack_d    = 1'b0;
    cmd_done_d   = 1'b0;
    cmd_result_d = cmd_result_q;
    dsp_ack_d    = 1'b0;
    dsp_valid_d  = 1'b0;
    dsp_data_d   = dsp_data_q;
    rf_a1_d      = rf_a1_q;
    rf_a2_d      = rf_a2_q;
    rf_a3_d      = rf_a3_q;
    rf_wd3_d     = rf_wd3_q;
    rf_we3_n_d   = 1'b1;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && dsp_req) begin
          rr_d = ~rr_q;
        end else begin
          rr_d = rr_q;
        end
        if (grant_cmd_s) begin
          cmd_ack_d = 1'b1;
          sel_d     = 1'b0;
          op_d      = cmd_op;
          rd_d      = cmd_rd;
          imm_sel_d = cmd_imm_sel;
          imm_d     = cmd_imm;
          no_wb_d   = cmd_no_wb;
          rf_a1_d   = cmd_rn;
          rf_a2_d   = cmd_rm;
          state_d   = S_RD_ADDR;
        end else if (grant_dsp_s) begin
          dsp_ack_d = 1'b1;
          sel_d     = 1'b1;
          rf_a1_d   = dsp_addr;
          state_d   = S_RD_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // Bank data for the addresses driven in RD_ADDR is now on rf_rd1/rf_rd2.
        if (!sel_q) begin
          alu_a_d  = rf_rd1;
          alu_b_d  = imm_sel_q ? imm_q : rf_rd2;
          alu_op_d = op_q;
        end else begin
          alu_a_d = alu_a_q;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (sel_q) begin
          dsp_data_d  = rf_rd1;
          dsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (no_wb_q) begin
          cmd_result_d = alu_result;
          cmd_done_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          rf_a3_d    = rd_q;
          rf_wd3_d   = alu_result;
          rf_we3_n_d = 1'b0;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        cmd_result_d = rf_wd3_q;
        cmd_done_d   = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset also forces the write enable inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= 1'b0;
      sel_q        <= 1'b0;
      op_q         <= '0;
      rd_q         <= '0;
      imm_sel_q    <= 1'b0;
      imm_q        <= '0;
      no_wb_q      <= 1'b0;
      cmd_ack_q    <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_result_q <= '0;
      dsp_ack_q    <= 1'b0;
      dsp_valid_q  <= 1'b0;
      dsp_data_q   <= '0;
      rf_a1_q      <= '0;
      rf_a2_q      <= '0;
      rf_a3_q      <= '0;
      rf_wd3_q     <= '0;
      rf_we3_n_q   <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      imm_sel_q    <= imm_sel_d;
      imm_q        <= imm_d;
      no_wb_q      <= no_wb_d;
      cmd_ack_q    <= cmd_ack_d;
      cmd_done_q   <= cmd_done_d;
      cmd_result_q <= cmd_result_d;
      dsp_ack_q    <= dsp_ack_d;
      dsp_valid_q  <= dsp_valid_d;
      dsp_data_q   <= dsp_data_d;
      rf_a1_q      <= rf_a1_d;
      rf_a2_q      <= rf_a2_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd3_q     <= rf_wd3_d;
      rf_we3_n_q   <= rf_we3_n_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign cmd_ack    = cmd_ack_q;
  assign cmd_done   = cmd_done_q;
  assign cmd_result = cmd_result_q;
  assign dsp_ack    = dsp_ack_q;
  assign dsp_valid  = dsp_valid_q;
  assign dsp_data   = dsp_data_q;
  assign rf_a1      = rf_a1_q;
  assign rf_a2      = rf_a2_q;
  assign rf_a3      = rf_a3_q;
  assign rf_wd3     = rf_wd3_q;
  assign rf_we3_n   = rf_we3_n_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;

endmodule
